// File: rtl/msj_esc_pwm_driver_pkg.sv
// ============================================================================
// msj_pwm_pkg : shared ESC driver types and the duty clamp helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package msj_pwm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2
    } esc_state_t;

    // Negative commands map to 0, oversize commands saturate at full scale.
    function automatic logic [31:0] clamp_duty(input logic signed [31:0] x, input int res_bits);
        longint lim;
        lim = (longint'(1) << res_bits) - 1;
        if (x < 0) return '0;
        if (longint'(x) > lim) return 32'(lim);
        return 32'(x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/msj_esc_pwm_driver_if.sv
// ============================================================================
// msj_esc_pwm_driver_if : command inputs and pulse/status outputs of one ESC
// Revision              : 1.0
// ============================================================================
`default_nettype none

interface msj_esc_pwm_driver_if #(
    parameter int RESOLUTION_BITS = 12
);
    logic                       enable;
    logic                       estop;
    logic                       ena;
    logic signed [31:0]         duty;
    logic signed [31:0]         zero_speed;
    logic                       pwm_out;
    logic                       armed;
    logic                       period_start;
    logic [RESOLUTION_BITS-1:0] duty_applied;

    modport master (
        output enable, estop, ena, duty, zero_speed,
        input  pwm_out, armed, period_start, duty_applied
    );

    modport slave (
        input  enable, estop, ena, duty, zero_speed,
        output pwm_out, armed, period_start, duty_applied
    );
endinterface

`default_nettype wire

// File: rtl/msj_esc_pwm_driver_timebase.sv
// ============================================================================
// msj_pwm_timebase : free-running prescaler and step counter for one period
// Revision         : 1.0
// ============================================================================
`default_nettype none

module msj_pwm_timebase #(
    parameter int PRESCALE        = 1,
    parameter int RESOLUTION_BITS = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [RESOLUTION_BITS-1:0] step_cnt,
    output logic                       period_start
);
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_prescale_check
        $error("msj_pwm_timebase: clock too slow for PWM frequency and resolution");
    end

    logic [PRESC_W-1:0] presc_cnt;
    logic               presc_wrap;

    assign presc_wrap = (presc_cnt == PRESC_MAX);

    // period_start is registered so it is low straight out of reset and
    // high exactly while both counters read zero afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_cnt    <= '0;
            step_cnt     <= '0;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= presc_wrap ? '0 : presc_cnt + PRESC_W'(1);
            if (presc_wrap) step_cnt <= step_cnt + RESOLUTION_BITS'(1);
            period_start <= presc_wrap && (step_cnt == '1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/msj_esc_pwm_driver.sv
// ============================================================================
// msj_esc_pwm_driver : signed duty command to armed, slew-limited ESC pulse
// Revision           : 1.0
// ============================================================================
`default_nettype none

module msj_esc_pwm_driver
    import msj_pwm_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ  = 50_000_000,
    parameter int PWM_FREQ_HZ     = 50,
    parameter int RESOLUTION_BITS = 12,
    parameter int ARM_PERIODS     = 100,
    parameter int SLEW_STEP       = 4
) (
    input  logic                clock,
    input  logic                reset,
    msj_esc_pwm_driver_if.slave bus
);
    localparam int STEPS    = 2 ** RESOLUTION_BITS;
    localparam int PRESCALE = CLOCK_SPEED_HZ / (PWM_FREQ_HZ * STEPS);
    localparam int ARM_W    = (ARM_PERIODS > 0) ? $clog2(ARM_PERIODS + 1) : 1;
    localparam logic [ARM_W-1:0]           ARM_LAST = ARM_W'(ARM_PERIODS);
    localparam logic [RESOLUTION_BITS-1:0] SLEW     = RESOLUTION_BITS'(SLEW_STEP);

    logic [RESOLUTION_BITS-1:0] step_cnt;
    logic                       period_start;

    msj_pwm_timebase #(
        .PRESCALE        (PRESCALE),
        .RESOLUTION_BITS (RESOLUTION_BITS)
    ) u_timebase (
        .clock        (clock),
        .reset        (reset),
        .step_cnt     (step_cnt),
        .period_start (period_start)
    );

    esc_state_t                 state, state_next;
    logic [ARM_W-1:0]           arm_cnt, arm_cnt_next;
    logic [RESOLUTION_BITS-1:0] target, target_next;
    logic [RESOLUTION_BITS-1:0] applied, applied_next;
    logic [RESOLUTION_BITS-1:0] slewed, zero_clamped, duty_clamped;
    logic                       pwm_q;

    assign zero_clamped = RESOLUTION_BITS'(clamp_duty(bus.zero_speed, RESOLUTION_BITS));
    assign duty_clamped = RESOLUTION_BITS'(clamp_duty(bus.duty, RESOLUTION_BITS));

    always_comb begin
        slewed = target;
        if (target > applied) begin
            if (target - applied > SLEW) slewed = applied + SLEW;
        end else if (applied - target > SLEW) begin
            slewed = applied - SLEW;
        end
    end

    always_comb begin
        state_next   = state;
        arm_cnt_next = arm_cnt;
        target_next  = target;
        applied_next = applied;
        if (!bus.enable) begin
            state_next   = DISARMED;
            arm_cnt_next = '0;
            if (period_start) applied_next = '0;
        end else if (state == DISARMED) begin
            if (period_start) begin
                applied_next = '0;
                if (!bus.estop) begin
                    state_next   = ARMING;
                    arm_cnt_next = '0;
                end
            end
        end else if (bus.estop) begin
            state_next   = ARMING;
            arm_cnt_next = '0;
            if (period_start) applied_next = zero_clamped;
        end else if (state == ARMING) begin
            if (period_start) begin
                if (arm_cnt == ARM_LAST) begin
                    state_next  = ARMED;
                    target_next = zero_clamped;
                end else begin
                    applied_next = zero_clamped;
                    arm_cnt_next = arm_cnt + ARM_W'(1);
                end
            end
        end else begin
            // Slew reads the pre-strobe target, so a coincident ena waits a period.
            if (period_start) applied_next = slewed;
            if (bus.ena) target_next = duty_clamped;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= DISARMED;
            arm_cnt <= '0;
            target  <= '0;
            applied <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state   <= state_next;
            arm_cnt <= arm_cnt_next;
            target  <= target_next;
            applied <= applied_next;
            pwm_q   <= (state_next != DISARMED) && (step_cnt < applied_next);
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.armed        = (state == ARMED);
    assign bus.period_start = period_start;
    assign bus.duty_applied = applied;
endmodule

`default_nettype wire

// File: tb/tb_msj_esc_pwm_driver.sv
// ============================================================================
// tb_msj_esc_pwm_driver : directed stimulus with a per-cycle behavioural model
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_msj_esc_pwm_driver;
    localparam int RB     = 4;
    localparam int STEPS  = 16;
    localparam int PRESC  = 2;
    localparam int PERIOD = 32;
    localparam int NARM   = 3;
    localparam int SLEW   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    msj_esc_pwm_driver_if #(.RESOLUTION_BITS(RB)) bus ();

    msj_esc_pwm_driver #(
        .CLOCK_SPEED_HZ  (32),
        .PWM_FREQ_HZ     (1),
        .RESOLUTION_BITS (RB),
        .ARM_PERIODS     (NARM),
        .SLEW_STEP       (SLEW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (0=disarmed 1=arming 2=armed) ----------------
    int k, m_st, m_arm, m_tgt, m_app, e_pwm, e_ps, d;
    bit ps;

    function automatic int mclamp(input int x);
        if (x < 0) return 0;
        if (x > STEPS - 1) return STEPS - 1;
        return x;
    endfunction

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                k = 0; m_st = 0; m_arm = 0; m_tgt = 0; m_app = 0; e_pwm = 0; e_ps = 0;
            end else begin
                ps = (k > 0) && (k % PERIOD == 0);
                if (!bus.enable) begin
                    m_st = 0; m_arm = 0;
                    if (ps) m_app = 0;
                end else if (m_st == 0) begin
                    if (ps) begin
                        m_app = 0;
                        if (!bus.estop) begin m_st = 1; m_arm = 0; end
                    end
                end else if (bus.estop) begin
                    m_st = 1; m_arm = 0;
                    if (ps) m_app = mclamp(bus.zero_speed);
                end else if (m_st == 1) begin
                    if (ps && m_arm == NARM) begin
                        m_st = 2; m_tgt = mclamp(bus.zero_speed);
                    end else if (ps) begin
                        m_app = mclamp(bus.zero_speed); m_arm++;
                    end
                end else begin
                    if (ps) begin
                        d = m_tgt - m_app;
                        if (d > SLEW) d = SLEW;
                        if (d < -SLEW) d = -SLEW;
                        m_app += d;
                    end
                    if (bus.ena) m_tgt = mclamp(bus.duty);
                end
                e_pwm = (m_st != 0 && ((k % PERIOD) / PRESC) < m_app) ? 1 : 0;
                k++;
                e_ps = (k % PERIOD == 0) ? 1 : 0;
            end
        end
    end

    always @(negedge clock) begin
        check("pwm_out", int'(bus.pwm_out), e_pwm);
        check("armed", int'(bus.armed), (m_st == 2) ? 1 : 0);
        check("period_start", int'(bus.period_start), e_ps);
        check("duty_applied", int'(bus.duty_applied), m_app);
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ps();
        int n = 0;
        @(negedge clock);
        while (!bus.period_start && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.period_start) check("ps_timeout", int'(bus.period_start), 1);
    endtask

    // Starts on a period_start sample and ends on the next one.
    task automatic measure(output int width, output int app, output int arm);
        width = 0; app = 0; arm = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clock);
            if (i == 0) begin
                app = int'(bus.duty_applied);
                arm = int'(bus.armed);
            end
            width += int'(bus.pwm_out);
        end
    endtask

    task automatic pulse_ena(input int dv);
        bus.duty = dv;
        bus.ena  = 1'b1;
        @(negedge clock);
        bus.ena  = 1'b0;
    endtask

    task automatic arm_sequence(input string tag);
        int w, a, r;
        wait_ps();
        measure(w, a, r);
        check({tag, "_entry_width"}, w, 0);
        check({tag, "_entry_applied"}, a, 0);
        for (int i = 0; i < NARM; i++) begin
            measure(w, a, r);
            check({tag, "_neutral_width"}, w, 10);
            check({tag, "_neutral_armed"}, r, 0);
        end
        measure(w, a, r);
        check({tag, "_armed"}, r, 1);
        check({tag, "_armed_applied"}, a, 5);
    endtask

    initial begin
        int w, a, r;
        bus.enable = 1'b0; bus.estop = 1'b0; bus.ena = 1'b0;
        bus.duty = 0; bus.zero_speed = 5;
        repeat (3) @(negedge clock);
        check("reset_pwm", int'(bus.pwm_out), 0);
        check("reset_armed", int'(bus.armed), 0);
        check("reset_ps", int'(bus.period_start), 0);
        check("reset_applied", int'(bus.duty_applied), 0);
        bus.enable = 1'b1;
        reset = 1'b0;

        arm_sequence("t1");

        repeat (3) @(negedge clock);
        pulse_ena(11);
        wait_ps();
        measure(w, a, r); check("t2_app1", a, 7);  check("t2_w1", w, 14);
        measure(w, a, r); check("t2_app2", a, 9);  check("t2_w2", w, 18);
        measure(w, a, r); check("t2_app3", a, 11); check("t2_w3", w, 22);

        repeat (3) @(negedge clock);
        pulse_ena(-7);
        wait_ps();
        for (int i = 0; i < 6; i++) measure(w, a, r);
        check("t3_neg_app", a, 0);
        check("t3_neg_w", w, 0);
        repeat (3) @(negedge clock);
        pulse_ena(100);
        wait_ps();
        for (int i = 0; i < 8; i++) measure(w, a, r);
        check("t3_max_app", a, 15);
        check("t3_max_w", w, 30);

        wait_ps();
        repeat (10) @(negedge clock);
        check("t4_mid_pulse", int'(bus.pwm_out), 1);
        bus.enable = 1'b0;
        @(negedge clock);
        check("t4_pwm_off", int'(bus.pwm_out), 0);
        check("t4_armed_off", int'(bus.armed), 0);
        repeat (4) @(negedge clock);
        bus.enable = 1'b1;
        arm_sequence("t4");

        bus.duty = 9;
        bus.ena  = 1'b1;
        @(negedge clock);
        bus.ena  = 1'b0;
        check("t5_coincident_app", int'(bus.duty_applied), 5);
        wait_ps();
        measure(w, a, r); check("t5_next_app", a, 7);

        repeat (3) @(negedge clock);
        pulse_ena(11);
        wait_ps();
        measure(w, a, r);
        measure(w, a, r); check("t6_at11", a, 11);
        repeat (5) @(negedge clock);
        bus.estop = 1'b1;
        @(negedge clock);
        bus.estop = 1'b0;
        check("t6_estop_armed", int'(bus.armed), 0);
        @(negedge clock);
        pulse_ena(2);
        wait_ps();
        for (int i = 0; i < NARM; i++) begin
            measure(w, a, r);
            check("t6_neutral_app", a, 5);
            check("t6_neutral_armed", r, 0);
        end
        measure(w, a, r);
        check("t6_rearmed", r, 1);
        check("t6_rearmed_app", a, 5);

        repeat (4) @(negedge clock);
        check("t6_pre_reset_pwm", int'(bus.pwm_out), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_pwm", int'(bus.pwm_out), 0);
        check("t6_async_armed", int'(bus.armed), 0);
        check("t6_async_applied", int'(bus.duty_applied), 0);
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
